// File: rtl/imgproc_sobel3x3_pkg.sv
// imgproc_sobel3x3_pkg
//   Shared types and constants for the streaming 3x3 Sobel filter.
//   - sobel_mode_e : runtime kernel selection carried with each frame
//   - pix_t        : default-width greyscale pixel
//   - PIPE_LAT     : input-beat to output-beat latency in clock cycles
package imgproc_sobel3x3_pkg;

  localparam int DATA_W_DEF = 12;
  localparam int PIPE_LAT   = 2;

  typedef logic [DATA_W_DEF-1:0] pix_t;

  typedef enum logic [1:0] {
    MODE_PASS = 2'd0,
    MODE_VERT = 2'd1,
    MODE_HORZ = 2'd2,
    MODE_MAG  = 2'd3
  } sobel_mode_e;

endpackage

// File: rtl/imgproc_sobel3x3_if.sv
// imgproc_sobel3x3_if
//   Pixel stream bundle around the Sobel filter.
//   Input side : iDATA (pixel), iDVAL (valid), iSOF (start of frame), iMODE (kernel)
//   Output side: oDATA (filtered pixel), oDVAL (valid), oMODE (mode in force)
//   master : the upstream source / bench (drives i*, observes o*)
//   slave  : the filter itself (consumes i*, drives o*)
interface imgproc_sobel3x3_if #(
  parameter int DATA_W = 12
) ();

  logic [DATA_W-1:0] iDATA;
  logic              iDVAL;
  logic              iSOF;
  logic [1:0]        iMODE;
  logic [DATA_W-1:0] oDATA;
  logic              oDVAL;
  logic [1:0]        oMODE;

  modport master (
    output iDATA, iDVAL, iSOF, iMODE,
    input  oDATA, oDVAL, oMODE
  );

  modport slave (
    input  iDATA, iDVAL, iSOF, iMODE,
    output oDATA, oDVAL, oMODE
  );

endinterface

// File: rtl/imgproc_sobel3x3_line_buffer_2tap.sv
// line_buffer_2tap
//   Two cascaded IMG_W-deep shift lines. Each enabled beat pushes i_data in;
//   o_tap1 is the pixel one line above the one being written, o_tap2 two lines above.
//   Ports: i_clk clock, i_clken shift enable (pixel valid), i_data pixel in,
//          o_tap1 row-1 tap, o_tap2 row-2 tap.
//   Contents are deliberately not reset; the consumer masks incomplete windows.
module line_buffer_2tap #(
  parameter int DATA_W = 12,
  parameter int IMG_W  = 640
) (
  input  logic              i_clk,
  input  logic              i_clken,
  input  logic [DATA_W-1:0] i_data,
  output logic [DATA_W-1:0] o_tap1,
  output logic [DATA_W-1:0] o_tap2
);

  logic [DATA_W-1:0] r_line1 [IMG_W];
  logic [DATA_W-1:0] r_line2 [IMG_W];

  // Shift both lines by one pixel on every valid beat; line 2 is fed from the end of line 1
  always_ff @(posedge i_clk) begin
    if (i_clken) begin
      r_line1[0] <= i_data;
      r_line2[0] <= r_line1[IMG_W-1];
      for (int i = 1; i < IMG_W; i++) begin
        r_line1[i] <= r_line1[i-1];
        r_line2[i] <= r_line2[i-1];
      end
    end
  end

  assign o_tap1 = r_line1[IMG_W-1];
  assign o_tap2 = r_line2[IMG_W-1];

endmodule

// File: rtl/imgproc_sobel3x3.sv
// imgproc_sobel3x3
//   Streaming 3x3 Sobel edge filter, one greyscale pixel per iDVAL beat.
//   Ports: iCLK clock, iRST synchronous active-high reset,
//          bus (slave) : iDATA/iDVAL/iSOF/iMODE in, oDATA/oDVAL/oMODE out.
//   Pipeline: window update + gradient registers (stage 1), kernel select,
//   shift and saturate into the output registers (stage 2). oDVAL is iDVAL
//   delayed exactly two cycles; windows touching rows/cols 0-1 output 0.
module imgproc_sobel3x3
  import imgproc_sobel3x3_pkg::*;
#(
  parameter int DATA_W = 12,
  parameter int IMG_W  = 640,
  parameter int IMG_H  = 480,
  parameter int SHIFT  = 2
) (
  input logic                 iCLK,
  input logic                 iRST,
  imgproc_sobel3x3_if.slave   bus
);

  localparam int CW = (IMG_W > 1) ? $clog2(IMG_W) : 1;
  localparam int RW = (IMG_H > 1) ? $clog2(IMG_H) : 1;
  localparam int GW = DATA_W + 3;
  localparam int MW = DATA_W + 4;
  localparam logic [CW-1:0] COL_LAST = CW'(IMG_W - 1);
  localparam logic [RW-1:0] ROW_LAST = RW'(IMG_H - 1);

  logic [CW-1:0]        r_col, w_col, w_col_nxt;
  logic [RW-1:0]        r_row, w_row, w_row_nxt;
  logic                 w_sof;
  sobel_mode_e          r_mode, w_mode;
  logic [DATA_W-1:0]    w_tap1, w_tap2;
  logic [DATA_W-1:0]    r_win [3][3];
  logic [DATA_W-1:0]    w_win [3][3];
  logic signed [GW-1:0] w_ext [3][3];
  logic signed [GW-1:0] w_gx, w_gy;
  logic signed [GW-1:0] r_s1_gx, r_s1_gy;
  logic [DATA_W-1:0]    r_s1_pass;
  logic                 r_s1_vld, r_s1_border;
  sobel_mode_e          r_s1_mode;
  logic [MW-1:0]        w_ax, w_ay, w_sel;
  logic [DATA_W-1:0]    w_sat;
  logic [DATA_W-1:0]    r_odata;
  logic                 r_odval;

  assign w_sof = bus.iDVAL & bus.iSOF;

  line_buffer_2tap #(.DATA_W(DATA_W), .IMG_W(IMG_W)) u_lb (
    .i_clk   (iCLK),
    .i_clken (bus.iDVAL),
    .i_data  (bus.iDATA),
    .o_tap1  (w_tap1),
    .o_tap2  (w_tap2)
  );

  // Coordinates of the incoming pixel (SOF resyncs to 0,0) and counter next-state
  always_comb begin
    if (w_sof) begin
      w_col = {CW{1'b0}};
      w_row = {RW{1'b0}};
    end else begin
      w_col = r_col;
      w_row = r_row;
    end
    if (w_col == COL_LAST) begin
      w_col_nxt = {CW{1'b0}};
      if (w_row == ROW_LAST) begin
        w_row_nxt = {RW{1'b0}};
      end else begin
        w_row_nxt = w_row + RW'(1);
      end
    end else begin
      w_col_nxt = w_col + CW'(1);
      w_row_nxt = w_row;
    end
  end

  // Mode for the incoming pixel: a new frame takes iMODE, otherwise the latched mode
  always_comb begin
    if (w_sof) begin
      w_mode = sobel_mode_e'(bus.iMODE);
    end else begin
      w_mode = r_mode;
    end
  end

  // Pixel counters and frame mode latch
  always_ff @(posedge iCLK) begin
    if (iRST) begin
      r_col  <= {CW{1'b0}};
      r_row  <= {RW{1'b0}};
      r_mode <= MODE_VERT;
    end else if (bus.iDVAL) begin
      r_col  <= w_col_nxt;
      r_row  <= w_row_nxt;
      r_mode <= w_mode;
    end
  end

  // Next window: shift left and append {row-2 tap, row-1 tap, new pixel} as right column
  always_comb begin
    for (int r = 0; r < 3; r++) begin
      for (int c = 0; c < 3; c++) begin
        w_win[r][c] = r_win[r][c];
      end
    end
    if (bus.iDVAL) begin
      for (int r = 0; r < 3; r++) begin
        w_win[r][0] = r_win[r][1];
        w_win[r][1] = r_win[r][2];
      end
      w_win[0][2] = w_tap2;
      w_win[1][2] = w_tap1;
      w_win[2][2] = bus.iDATA;
    end else begin
      w_win[2][2] = r_win[2][2];
    end
  end

  // Window storage; stale content after reset is hidden by border masking
  always_ff @(posedge iCLK) begin
    if (bus.iDVAL) begin
      for (int r = 0; r < 3; r++) begin
        for (int c = 0; c < 3; c++) begin
          r_win[r][c] <= w_win[r][c];
        end
      end
    end
  end

  // Gradients on the updated window; unsigned pixels are zero-extended before signed math
  always_comb begin
    for (int r = 0; r < 3; r++) begin
      for (int c = 0; c < 3; c++) begin
        w_ext[r][c] = $signed({3'b000, w_win[r][c]});
      end
    end
    w_gx = (w_ext[0][2] + (w_ext[1][2] <<< 1) + w_ext[2][2])
         - (w_ext[0][0] + (w_ext[1][0] <<< 1) + w_ext[2][0]);
    w_gy = (w_ext[2][0] + (w_ext[2][1] <<< 1) + w_ext[2][2])
         - (w_ext[0][0] + (w_ext[0][1] <<< 1) + w_ext[0][2]);
  end

  // Stage 1: gradients, centre pixel, border flag, per-pixel mode and valid
  always_ff @(posedge iCLK) begin
    if (iRST) begin
      r_s1_vld    <= 1'b0;
      r_s1_gx     <= {GW{1'b0}};
      r_s1_gy     <= {GW{1'b0}};
      r_s1_pass   <= {DATA_W{1'b0}};
      r_s1_border <= 1'b1;
      r_s1_mode   <= MODE_VERT;
    end else begin
      r_s1_vld    <= bus.iDVAL;
      r_s1_gx     <= w_gx;
      r_s1_gy     <= w_gy;
      r_s1_pass   <= w_win[1][1];
      r_s1_border <= (w_row < RW'(2)) || (w_col < CW'(2));
      r_s1_mode   <= w_mode;
    end
  end

  // Stage 2 datapath: magnitudes, kernel select + shift, saturation
  always_comb begin
    if (r_s1_gx[GW-1]) begin
      w_ax = MW'($unsigned(-r_s1_gx));
    end else begin
      w_ax = MW'($unsigned(r_s1_gx));
    end
    if (r_s1_gy[GW-1]) begin
      w_ay = MW'($unsigned(-r_s1_gy));
    end else begin
      w_ay = MW'($unsigned(r_s1_gy));
    end
    case (r_s1_mode)
      MODE_PASS: w_sel = {4'b0000, r_s1_pass};
      MODE_VERT: w_sel = w_ay >> SHIFT;
      MODE_HORZ: w_sel = w_ax >> SHIFT;
      MODE_MAG:  w_sel = (w_ax + w_ay) >> SHIFT;
      default:   w_sel = {MW{1'b0}};
    endcase
    if (|w_sel[MW-1:DATA_W]) begin
      w_sat = {DATA_W{1'b1}};
    end else begin
      w_sat = w_sel[DATA_W-1:0];
    end
  end

  // Stage 2 registers: output 0 for incomplete windows, valid follows stage 1
  always_ff @(posedge iCLK) begin
    if (iRST) begin
      r_odval <= 1'b0;
      r_odata <= {DATA_W{1'b0}};
    end else begin
      r_odval <= r_s1_vld;
      r_odata <= (r_s1_vld && !r_s1_border) ? w_sat : {DATA_W{1'b0}};
    end
  end

  assign bus.oDATA = r_odata;
  assign bus.oDVAL = r_odval;
  assign bus.oMODE = r_mode;

endmodule

// File: tb/tb_imgproc_sobel3x3.sv
// tb_imgproc_sobel3x3
//   Directed frames on an 8x6 image with SHIFT=2. Stimulus pushes the expected
//   output (data, mode, arrival cycle) into a queue; a monitor on the falling
//   edge pops and compares whenever oDVAL is high.
module tb_imgproc_sobel3x3;
  import imgproc_sobel3x3_pkg::*;

  localparam int DW = 12;
  localparam int IW = 8;
  localparam int IH = 6;
  localparam int SH = 2;

  typedef struct {
    logic [DW-1:0] data;
    logic [1:0]    mode;
    int            cyc;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   dval_cnt = 0;
  exp_t sb_q[$];
  exp_t mon_e;
  logic [DW-1:0] img [IH][IW];

  always #5 clk = ~clk;

  imgproc_sobel3x3_if #(.DATA_W(DW)) bus ();

  imgproc_sobel3x3 #(.DATA_W(DW), .IMG_W(IW), .IMG_H(IH), .SHIFT(SH)) dut (
    .iCLK (clk),
    .iRST (rst),
    .bus  (bus)
  );

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: every oDVAL beat must match the oldest outstanding expectation
  always @(negedge clk) begin
    if (bus.oDVAL) begin
      dval_cnt++;
      if (sb_q.size() == 0) begin
        chk("unexpected_odval", 1, 0);
      end else begin
        mon_e = sb_q.pop_front();
        chk("odata", int'(bus.oDATA), int'(mon_e.data));
        chk("omode", int'(bus.oMODE), int'(mon_e.mode));
        chk("latency_cycle", cyc, mon_e.cyc);
      end
    end
  end

  function automatic logic [DW-1:0] pat(input int kind, input int c, input int r);
    case (kind)
      0:       return 12'h800;
      1:       return (c < 4) ? 12'h000 : 12'h100;
      2:       return (r < 3) ? 12'h000 : 12'hFFF;
      3:       return DW'((c * c * 53 + r * 311) & 'hFFF);
      4:       return (c + r >= 6) ? 12'hFFF : 12'h000;
      default: return DW'((c * 97 + r * 211 + 5) & 'hFFF);
    endcase
  endfunction

  function automatic int px(input int x, input int y);
    return int'(img[y][x]);
  endfunction

  // Reference convolution on the stored frame, window centred one pixel up-left
  function automatic logic [DW-1:0] model(input int mode, input int c, input int r);
    int x, y, gx, gy, v;
    x  = c - 1;
    y  = r - 1;
    gx = (px(x+1, y-1) + 2 * px(x+1, y) + px(x+1, y+1)) - (px(x-1, y-1) + 2 * px(x-1, y) + px(x-1, y+1));
    gy = (px(x-1, y+1) + 2 * px(x, y+1) + px(x+1, y+1)) - (px(x-1, y-1) + 2 * px(x, y-1) + px(x+1, y-1));
    if (gx < 0) gx = -gx;
    if (gy < 0) gy = -gy;
    case (mode)
      0:       v = px(x, y);
      1:       v = gy >> SH;
      2:       v = gx >> SH;
      default: v = (gx + gy) >> SH;
    endcase
    if (v > 4095) v = 4095;
    return DW'(v);
  endfunction

  // Hand-derived expectations for the simple patterns, reference model otherwise
  function automatic logic [DW-1:0] exp_px(input int kind, input int mode, input int c, input int r);
    if (r < 2 || c < 2) return 12'h000;
    case (kind)
      0:       return 12'h000;
      1:       return (c == 4 || c == 5) ? 12'h100 : 12'h000;
      2:       return (r == 3 || r == 4) ? 12'hFFF : 12'h000;
      default: return model(mode, c, r);
    endcase
  endfunction

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
      bus.iDVAL = 1'b0;
      bus.iSOF  = 1'b0;
    end
  endtask

  task automatic drive_px(input logic [DW-1:0] v, input logic sof, input logic [1:0] imode,
                          input logic [DW-1:0] expv, input logic [1:0] expm);
    @(posedge clk);
    #1;
    bus.iDATA = v;
    bus.iDVAL = 1'b1;
    bus.iSOF  = sof;
    bus.iMODE = imode;
    sb_q.push_back('{data: expv, mode: expm, cyc: cyc + PIPE_LAT});
  endtask

  // One full frame; mid_mode >= 0 changes iMODE part-way through (must be ignored)
  task automatic send_frame(input int kind, input int fmode, input int duty, input int mid_mode);
    logic [DW-1:0] v;
    logic [1:0]    im;
    int            n;
    im = 2'(fmode);
    for (int r = 0; r < IH; r++) begin
      for (int c = 0; c < IW; c++) begin
        if (mid_mode >= 0 && (r * IW + c) == 20) im = 2'(mid_mode);
        v = pat(kind, c, r);
        img[r][c] = v;
        drive_px(v, (r == 0 && c == 0), im, exp_px(kind, fmode, c, r), 2'(fmode));
        if (duty > 0) begin
          n = 0;
          while ($urandom_range(0, 99) >= duty && n < 10) begin
            idle(1);
            n++;
          end
        end
      end
    end
  endtask

  // Frame cut by a one-cycle reset at pixel (5,3); in-flight results are dropped
  task automatic send_until_reset(input int kind, input int fmode);
    logic [DW-1:0] v;
    for (int r = 0; r < IH; r++) begin
      for (int c = 0; c < IW; c++) begin
        v = pat(kind, c, r);
        img[r][c] = v;
        if (r == 3 && c == 5) begin
          @(posedge clk);
          #1;
          rst       = 1'b1;
          bus.iDATA = v;
          bus.iDVAL = 1'b1;
          bus.iSOF  = 1'b0;
          @(posedge clk);
          #1;
          rst       = 1'b0;
          bus.iDVAL = 1'b0;
          sb_q.delete();
          @(negedge clk);
          chk("rst_odval_c1", int'(bus.oDVAL), 0);
          chk("rst_omode", int'(bus.oMODE), 1);
          @(negedge clk);
          chk("rst_odval_c2", int'(bus.oDVAL), 0);
          return;
        end
        drive_px(v, (r == 0 && c == 0), 2'(fmode), exp_px(kind, fmode, c, r), 2'(fmode));
      end
    end
  endtask

  task automatic drain();
    idle(1);
    for (int i = 0; i < 20 && sb_q.size() != 0; i++) @(posedge clk);
    idle(2);
    chk("drain_outstanding", sb_q.size(), 0);
    sb_q.delete();
  endtask

  initial begin
    bus.iDATA = 12'h000;
    bus.iDVAL = 1'b0;
    bus.iSOF  = 1'b0;
    bus.iMODE = 2'd2;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_odval", int'(bus.oDVAL), 0);
    chk("reset_odata", int'(bus.oDATA), 0);
    chk("reset_omode", int'(bus.oMODE), 1);
    @(posedge clk);
    #1;
    rst = 1'b0;

    // constant frame, magnitude mode: all zero, 48 beats
    dval_cnt = 0;
    send_frame(0, 3, 0, -1);
    drain();
    chk("t1_beat_count", dval_cnt, IW * IH);

    // vertical step, horizontal kernel
    send_frame(1, 2, 0, -1);
    drain();
    // horizontal step, vertical kernel then magnitude
    send_frame(2, 1, 0, -1);
    drain();
    send_frame(2, 3, 0, -1);
    drain();
    // iMODE changed mid-frame is ignored until the next SOF
    send_frame(3, 1, 0, 2);
    drain();
    send_frame(3, 2, 0, -1);
    drain();
    // pass mode with ~30% valid duty
    send_frame(5, 0, 30, -1);
    drain();
    // reset mid-frame, then a fresh frame that saturates in magnitude mode
    send_until_reset(3, 2);
    send_frame(4, 3, 0, -1);
    drain();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1);
  end

endmodule
